// File: rtl/aes_128_dec.sv
// Iterative AES-128 decryption engine. It expands the key forward to rk10, then runs
// one inverse round per cycle, walking the key schedule backwards as it goes.
module aes_128_dec (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key,
   input  logic [127:0] ct,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

   state_t       state_q, state_d;
   logic [3:0]   rc_q, rc_d;
   logic [127:0] data_q, data_d;
   logic [127:0] rk_q, rk_d;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; zero maps to zero without a special case.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] s;
      logic [7:0] e;
      r = 8'h01;
      s = x;
      e = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gf_mul(r, s);
         s = gf_mul(s, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] y;
      y = gf_inv(x);
      return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] z;
      z = x ^ 8'h63;
      return gf_inv(rotl(z, 1) ^ rotl(z, 3) ^ rotl(z, 6));
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Key step: the four S-boxes are shared between forward and inverse directions.
   logic        fwd;
   logic [3:0]  rc_idx;
   logic [31:0] w0, w1, w2, w3, v1, v2, v3;
   logic [31:0] sel_w, rot_w, sub_w, kx;
   logic [31:0] n0, n1, n2, n3;
   logic [127:0] rk_next, rk_prev;

   assign fwd    = (state_q == KEXP);
   assign rc_idx = fwd ? rc_q + 4'd1 : rc_q;
   assign w0 = rk_q[127:96];
   assign w1 = rk_q[95:64];
   assign w2 = rk_q[63:32];
   assign w3 = rk_q[31:0];
   assign v3 = w3 ^ w2;
   assign v2 = w2 ^ w1;
   assign v1 = w1 ^ w0;
   assign sel_w = fwd ? w3 : v3;
   assign rot_w = {sel_w[23:0], sel_w[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_key_sbox
         assign sub_w[8*gi +: 8] = sbox(rot_w[8*gi +: 8]);
      end
   endgenerate

   assign kx = sub_w ^ {rcon(rc_idx), 24'h000000};
   assign n0 = w0 ^ kx;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign rk_next = {n0, n1, n2, n3};
   assign rk_prev = {w0 ^ kx, v1, v2, v3};

   // Inverse round: InvShiftRows folded into the byte selection ahead of InvSubBytes.
   logic [127:0] isb, ark, imc;

   generate
      for (gi = 0; gi < 16; gi++) begin : g_inv_sub
         localparam int R = gi % 4;
         localparam int C = gi / 4;
         localparam int S = 4 * ((C - R + 4) % 4) + R;
         assign isb[127 - 8*gi -: 8] = inv_sbox(data_q[127 - 8*S -: 8]);
      end
   endgenerate

   assign ark = isb ^ rk_prev;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_inv_mix
         logic [7:0] a0, a1, a2, a3;
         assign a0 = ark[127 - 32*gi -: 8];
         assign a1 = ark[119 - 32*gi -: 8];
         assign a2 = ark[111 - 32*gi -: 8];
         assign a3 = ark[103 - 32*gi -: 8];
         assign imc[127 - 32*gi -: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1)
                                      ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
         assign imc[119 - 32*gi -: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1)
                                      ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
         assign imc[111 - 32*gi -: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1)
                                      ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
         assign imc[103 - 32*gi -: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1)
                                      ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      rc_d    = rc_q;
      data_d  = data_q;
      rk_d    = rk_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = ct;
               rk_d    = key;
               rc_d    = 4'd0;
               state_d = KEXP;
            end
         end
         KEXP: begin
            rk_d = rk_next;
            rc_d = rc_q + 4'd1;
            if (rc_q == 4'd9) begin
               data_d  = data_q ^ rk_next;
               state_d = ROUND;
            end
         end
         ROUND: begin
            rk_d = rk_prev;
            rc_d = rc_q - 4'd1;
            if (rc_q == 4'd1) begin
               data_d  = ark;
               state_d = DONE;
            end else begin
               data_d = imc;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rc_q    <= 4'd0;
         data_q  <= 128'h0;
         rk_q    <= 128'h0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         data_q  <= data_d;
         rk_q    <= rk_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == KEXP) || (state_q == ROUND);
   assign pt        = data_q;

endmodule

// File: tb/tb_aes_128_dec.sv
// Directed-vector bench for aes_128_dec: known-answer blocks, latency, backpressure,
// back-to-back throughput and mid-operation reset.
module tb_aes_128_dec;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] key;
   logic [127:0] ct;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] pt;
   logic         busy;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   // All-zero key and plaintext encrypt to this well-known block.
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   int n_checks = 0;
   int n_fail   = 0;

   aes_128_dec dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .key       (key),
      .ct        (ct),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt        (pt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send(input logic [127:0] k, input logic [127:0] c, output bit ok);
      ok       = 1'b0;
      key      = k;
      ct       = c;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; key = C1_KEY; ct = C1_CT; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy (in_valid during rst): got %b, expected 0", busy); end
      n_checks++; if (pt !== 128'h0) begin n_fail++; $display("FAIL reset_pt: got %h, expected 0", pt); end
      $display("test_reset done");
   endtask

   task automatic test_block(input string name, input logic [127:0] k,
                             input logic [127:0] c, input logic [127:0] p);
      bit ok;
      int n;
      send(k, c, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s_accept: got %b, expected 1", name, ok); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b, expected 1", name, busy); end
      wait_valid(n);
      n_checks++; if (n !== 20) begin n_fail++; $display("FAIL %s_latency: got %0d, expected 20", name, n); end
      n_checks++; if (pt !== p) begin n_fail++; $display("FAIL %s_pt: got %h, expected %h", name, pt, p); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_in_ready_done: got %b, expected 0", name, in_ready); end
      consume();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL %s_release: got valid=%b ready=%b, expected valid=0 ready=1", name, out_valid, in_ready);
      end
      $display("test_block %s: pt=%h latency=%0d", name, pt, n);
   endtask

   task automatic test_backpressure();
      bit ok;
      int n;
      send(C1_KEY, C1_CT, ok);
      wait_valid(n);
      n_checks++; if (n !== 20) begin n_fail++; $display("FAIL bp_latency: got %0d, expected 20", n); end
      key = B_KEY; ct = B_CT;
      for (int i = 0; i < 15; i++) begin
         in_valid = i[0];
         @(posedge clk); #1;
         n_checks++; if (pt !== C1_PT) begin n_fail++; $display("FAIL bp_pt_stable[%0d]: got %h, expected %h", i, pt, C1_PT); end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held[%0d]: got %b, expected 1", i, out_valid); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b, expected 0", i, in_ready); end
      end
      in_valid = 1'b0;
      consume();
      n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_release: got ready=%b busy=%b valid=%b, expected 1 0 0", in_ready, busy, out_valid);
      end
      n_checks++; if (pt !== C1_PT) begin n_fail++; $display("FAIL bp_not_queued_pt: got %h, expected %h", pt, C1_PT); end
      $display("test_backpressure done");
   endtask

   task automatic test_back_to_back();
      int n;
      in_valid = 1'b1; key = C1_KEY; ct = C1_CT; out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_first_accept: got busy=%b, expected 1", busy); end
      key = B_KEY; ct = B_CT;
      wait_valid(n);
      n_checks++; if (n !== 20) begin n_fail++; $display("FAIL b2b_latency1: got %0d, expected 20", n); end
      n_checks++; if (pt !== C1_PT) begin n_fail++; $display("FAIL b2b_pt1: got %h, expected %h", pt, C1_PT); end
      // Handshake edge, one IDLE cycle for the re-accept, then 20 cycles of work.
      @(posedge clk); #1;
      wait_valid(n);
      in_valid = 1'b0;
      n_checks++; if (n !== 21) begin n_fail++; $display("FAIL b2b_gap: got %0d, expected 21", n); end
      n_checks++; if (pt !== B_PT) begin n_fail++; $display("FAIL b2b_pt2: got %h, expected %h", pt, B_PT); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_idle: got ready=%b busy=%b, expected 1 0", in_ready, busy);
      end
      $display("test_back_to_back: gap=%0d", n);
   endtask

   task automatic test_reset_mid();
      bit ok;
      send(C1_KEY, C1_CT, ok);
      repeat (11) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b, expected 1", busy); end
      rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rmid_async: got valid=%b busy=%b, expected 0 0", out_valid, busy);
      end
      n_checks++; if (pt !== 128'h0) begin n_fail++; $display("FAIL rmid_pt: got %h, expected 0", pt); end
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b, expected 1", in_ready); end
      $display("test_reset_mid done");
      test_block("c1_after_reset", C1_KEY, C1_CT, C1_PT);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_block("fips_c1", C1_KEY, C1_CT, C1_PT);
      test_block("fips_b", B_KEY, B_CT, B_PT);
      test_block("zero", 128'h0, Z_CT, 128'h0);
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
